// File: rtl/mult_datapath.sv
// Shift-add datapath for the sequential multiplier: operand shifters, product
// accumulator and iteration counter, steered cycle by cycle by the multiplier FSM.
module mult_datapath #(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic                 a_sel_i,
    input  logic                 b_sel_i,
    input  logic                 prod_sel_i,
    input  logic                 add_sel_i,
    input  logic                 cont_flag_i,
    output logic                 b_lsb_o,
    output logic [CW-1:0]        cont_o,
    output logic                 cont_done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int PW = 2 * WIDTH;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [PW-1:0]    a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             active;

    // Once the counter reaches WIDTH every shift/accumulate stops, freezing the result.
    assign active = (cnt_q < CNT_MAX);

    always_comb begin
        a_d = a_q;
        if (!a_sel_i) begin
            a_d = {{WIDTH{1'b0}}, a_i};
        end else if (active) begin
            a_d = a_q << 1;
        end
    end

    always_comb begin
        b_d = b_q;
        if (!b_sel_i) begin
            b_d = b_i;
        end else if (active) begin
            b_d = b_q >> 1;
        end
    end

    // The add uses the pre-shift a_q, so a same-cycle load or shift never disturbs it.
    always_comb begin
        prod_d = prod_q;
        if (!prod_sel_i) begin
            prod_d = '0;
        end else if (active && add_sel_i) begin
            prod_d = prod_q + a_q;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!prod_sel_i) begin
            cnt_d = '0;
        end else if (cont_flag_i && active) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            cnt_q  <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            prod_q <= prod_d;
            cnt_q  <= cnt_d;
        end
    end

    assign b_lsb_o     = b_q[0];
    assign cont_o      = cnt_q;
    assign cont_done_o = (cnt_q == CNT_MAX);
    assign product_o   = prod_q;

endmodule

// File: tb/tb_mult_datapath.sv
// Bench for mult_datapath: directed and random multiplications checked against
// a closed-form model of the partial product after k iterations.
module tb_mult_datapath;

    localparam int W  = 32;
    localparam int CW = 6;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [W-1:0]    a_i, b_i;
    logic            a_sel_i, b_sel_i, prod_sel_i, add_sel_i, cont_flag_i;
    logic            b_lsb_o;
    logic [CW-1:0]   cont_o;
    logic            cont_done_o;
    logic [2*W-1:0]  product_o;

    int n_checks = 0;
    int n_pass   = 0;

    mult_datapath #(.WIDTH(W), .CW(CW)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .a_i         (a_i),
        .b_i         (b_i),
        .a_sel_i     (a_sel_i),
        .b_sel_i     (b_sel_i),
        .prod_sel_i  (prod_sel_i),
        .add_sel_i   (add_sel_i),
        .cont_flag_i (cont_flag_i),
        .b_lsb_o     (b_lsb_o),
        .cont_o      (cont_o),
        .cont_done_o (cont_done_o),
        .product_o   (product_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        else n_pass++;
    endtask

    // Partial product after k iterations: a times the low k bits of b.
    function automatic logic [63:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b, input int k);
        logic [63:0] mask;
        mask = (64'd1 << k) - 64'd1;
        return {32'd0, a} * ({32'd0, b} & mask);
    endfunction

    function automatic logic model_lsb(input logic [W-1:0] b, input int k);
        return (k < W) ? b[k] : 1'b0;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input int k);
        check({tag, ".prod"}, product_o, model_prod(a, b, k));
        check({tag, ".cont"}, 64'(cont_o), 64'(k));
        check({tag, ".lsb"},  64'(b_lsb_o), 64'(model_lsb(b, k)));
        check({tag, ".done"}, 64'(cont_done_o), 64'(k == W));
    endtask

    // Load a/b, then run n accumulate cycles with add_sel following bit k of b.
    task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input int n);
        a_i = a; b_i = b;
        a_sel_i = 0; b_sel_i = 0; prod_sel_i = 0; add_sel_i = 0; cont_flag_i = 0;
        step();
        check_state({tag, ".load"}, a, b, 0);
        for (int k = 0; k < n; k++) begin
            a_sel_i = 1; b_sel_i = 1; prod_sel_i = 1; cont_flag_i = 1;
            add_sel_i = b[k];
            a_i = $urandom; b_i = $urandom;
            step();
            check_state($sformatf("%s.it%0d", tag, k + 1), a, b, k + 1);
        end
    endtask

    task automatic hold_done(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            a_sel_i = 1; b_sel_i = 1; prod_sel_i = 1; add_sel_i = 1; cont_flag_i = 1;
            a_i = $urandom; b_i = $urandom;
            step();
            check_state($sformatf("%s.hold%0d", tag, i), a, b, W);
        end
    endtask

    initial begin
        rst_ni = 0;
        a_i = '0; b_i = '0;
        a_sel_i = 1; b_sel_i = 1; prod_sel_i = 1; add_sel_i = 0; cont_flag_i = 1;
        step(); step();
        check("rst.prod", product_o, 64'd0);
        check("rst.cont", 64'(cont_o), 64'd0);
        check("rst.lsb",  64'(b_lsb_o), 64'd0);
        check("rst.done", 64'(cont_done_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1;

        run("3x5", 32'd3, 32'd5, W);
        run("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, W);
        check("ffxff.final", product_o, 64'hFFFF_FFFE_0000_0001);
        run("axz", 32'h1234_5678, 32'd0, W);
        run("zxb", 32'd0, 32'hFFFF_FFFF, W);
        hold_done("freeze", 32'd0, 32'hFFFF_FFFF, 10);

        // Async reset mid-run: outputs clear before the next edge.
        run("rstrun", 32'hDEAD_BEEF, 32'hCAFE_F00D, 17);
        @(negedge clk_i);
        rst_ni = 0;
        #1;
        check("arst.prod", product_o, 64'd0);
        check("arst.cont", 64'(cont_o), 64'd0);
        check("arst.lsb",  64'(b_lsb_o), 64'd0);
        #2;
        rst_ni = 1;
        run("7x9", 32'd7, 32'd9, W);
        check("7x9.final", product_o, 64'd63);

        // Reload at iteration 10 restarts cleanly.
        run("pre", 32'h0F0F_0F0F, 32'hF0F0_F0F0, 10);
        run("2x3", 32'd2, 32'd3, W);
        check("2x3.final", product_o, 64'd6);

        for (int r = 0; r < 20; r++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom; rb = $urandom;
            run($sformatf("rnd%0d", r), ra, rb, W);
            if (r % 5 == 0) hold_done($sformatf("rnd%0d", r), ra, rb, 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mult_datapath.md
Name: mult_datapath

Overview:
- Shift-add datapath for the sequential multiplier. It is the stage directly controlled by the multiplier FSM.
- It consumes the FSM selects (a_sel, b_sel, prod_sel, add_sel, cont_flag) and returns the status the FSM branches on (b_lsb, iteration count, done flag).
- It holds the operand shift registers, the 2*WIDTH-bit product accumulator and the iteration counter.
- The final product stays frozen once the iteration count reaches WIDTH, so it remains stable while the FSM waits in DONE for ack.

Parameters:
- WIDTH, 32, operand width in bits.
- CW, 6, counter width; must satisfy 2^CW > WIDTH.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- a_in  in  WIDTH  multiplicand, sampled when a_sel=0.
- b_in  in  WIDTH  multiplier, sampled when b_sel=0.
- a_sel  in  1  0 = load a_in, 1 = shift a left.
- b_sel  in  1  0 = load b_in, 1 = shift b right.
- prod_sel  in  1  0 = clear product and counter, 1 = accumulate.
- add_sel  in  1  1 = add current a into product this cycle.
- cont_flag  in  1  1 = counter enabled.
- b_lsb  out  1  bit 0 of b register (combinational from register).
- cont  out  CW  iterations completed.
- cont_done  out  1  cont == WIDTH (combinational from register).
- product  out  2*WIDTH  accumulator contents.

Behaviour:
- Internal registers:
  - a_reg, 2*WIDTH bits, with a_in zero-extended.
  - b_reg, WIDTH bits.
  - prod_reg, 2*WIDTH bits.
  - cnt, CW bits.
- Reset low, asynchronous: a_reg, b_reg, prod_reg and cnt go to 0 immediately. Hence b_lsb=0, cont=0, cont_done=0, product=0.
- Reset deassertion takes effect at the next rising Clock edge. No partial-operation state survives reset.
- "active" = (cnt < WIDTH). All shift, accumulate and count updates below occur only when active, except loads and clears, which always apply.
- a_reg each edge:
  - a_sel=0: a_reg <= {WIDTH'b0, a_in}.
  - a_sel=1 and active: a_reg <= a_reg << 1.
  - Otherwise hold.
- b_reg each edge:
  - b_sel=0: b_reg <= b_in.
  - b_sel=1 and active: b_reg <= b_reg >> 1, zero fill.
  - Otherwise hold.
- prod_reg each edge:
  - prod_sel=0: prod_reg <= 0.
  - prod_sel=1, active, add_sel=1: prod_reg <= prod_reg + a_reg, modulo 2^(2*WIDTH).
  - Otherwise hold.
  - Add and shift in the same cycle use the pre-shift a_reg.
- cnt each edge:
  - prod_sel=0: cnt <= 0.
  - prod_sel=1, cont_flag=1, active: cnt <= cnt + 1.
  - Otherwise hold. cnt saturates at WIDTH and never wraps.
- Latency: one load cycle (all selects 0), then WIDTH accumulate cycles with add_sel = b_lsb. After the WIDTH-th accumulate edge, cont_done=1 and product = a_in*b_in exactly.
- Freeze: once cnt == WIDTH, a_reg, b_reg and prod_reg hold regardless of a_sel, b_sel or add_sel, as long as a_sel, b_sel and prod_sel stay 1.
  - prod_sel=0 releases the freeze: clears prod_reg and cnt.
  - a_sel=0 or b_sel=0 reloads its operand register even while frozen.
- cont_flag=0 with prod_sel=1 and active: cnt holds, but a_reg, b_reg and prod_reg still shift and accumulate. The controller is responsible for keeping cont_flag=1 during CALC.
- Simultaneous load with prod_sel=1: load wins for the operand register, and prod_reg accumulates using the old a_reg.
- The datapath never inspects add_sel validity. add_sel=1 with b_lsb=0 adds a_reg as commanded.
- No overflow is possible for a full WIDTH x WIDTH product in 2*WIDTH bits.

Test Plan:
- Load a=3, b=5, then 32 cycles with add_sel=b_lsb -> product=15, cont=32, cont_done=1 on cycle 33 after load; b_lsb sequence starts 1,0,1,0.
- a=b=0xFFFFFFFF, full run -> product=0xFFFFFFFE00000001; no wrap; cont stays 32.
- a=0x12345678, b=0 -> b_lsb=0 every cycle, product=0 at done; a=0, b=0xFFFFFFFF -> product=0.
- After done, hold a_sel=b_sel=prod_sel=add_sel=1 for 10 more cycles with new a_in/b_in values -> product, cont and b_lsb unchanged.
- Reset pulled low at iteration 17 -> same-cycle async clear, product=0 and cont=0 before the next edge. Then load 7x9 -> 63.
- Reload mid-run by driving prod_sel=0 and a_sel=b_sel=0 at iteration 10 with a=2, b=3 -> cont=0, prod=0; fresh run ends with product=6.
